// File: rtl/mem_bank_ctrl_pkg.sv
// Package: mem_bank_ctrl_pkg
// Purpose: Constants and types shared by the mem_bank initiator.
//  - MODE_WRITING / MODE_PLAYBACK : encodings of the mem_bank mode input
//  - state_e                      : controller FSM states
package mem_bank_ctrl_pkg;

    localparam logic MODE_WRITING  = 1'b0;
    localparam logic MODE_PLAYBACK = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_READY = 2'd1,
        ST_SYNC       = 2'd2,
        ST_PLAY       = 2'd3
    } state_e;

endpackage

// File: rtl/mem_bank_ctrl.sv
// Module: mem_bank_ctrl
// Purpose: Initiator side of the mem_bank capture/playback interface. Forwards
//  front-end sample strobes into mem_bank while it is writing. On a start request
//  it waits for mem_bank ready, switches it to playback for a number of frames,
//  then returns it to writing.
// Ports:
//  clk, reset_n           clock, asynchronous active-low reset
//  fe_sample, fe_strobe   front-end sample and its valid strobe
//  start, num_passes      playback request and frame count (0 means 1)
//  mb_ready               mem_bank ready
//  mb_frame_start/_end    mem_bank frame markers
//  mb_data_in/_avail      registered sample path into mem_bank
//  mb_mode                registered mem_bank mode
//  busy, done             activity flag and end-of-request pulse
//  pass_count             completed passes of the current request
//  sync_err               sticky frame_start timeout flag
module mem_bank_ctrl
    import mem_bank_ctrl_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 3,
    parameter int PASS_WIDTH   = 8,
    parameter int SYNC_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [SAMPLE_WIDTH-1:0] fe_sample,
    input  logic                    fe_strobe,
    input  logic                    start,
    input  logic [PASS_WIDTH-1:0]   num_passes,
    input  logic                    mb_ready,
    input  logic                    mb_frame_start,
    input  logic                    mb_frame_end,
    output logic [SAMPLE_WIDTH-1:0] mb_data_in,
    output logic                    mb_data_avail,
    output logic                    mb_mode,
    output logic                    busy,
    output logic                    done,
    output logic [PASS_WIDTH-1:0]   pass_count,
    output logic                    sync_err
);

    localparam int TMO_W = $clog2(SYNC_TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SYNC_TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic                    mode_q, mode_d;
    logic [SAMPLE_WIDTH-1:0] data_in_q, data_in_d;
    logic                    data_avail_q, data_avail_d;
    logic                    done_q, done_d;
    logic                    sync_err_q, sync_err_d;
    logic [PASS_WIDTH-1:0]   passes_q, passes_d;
    logic [PASS_WIDTH-1:0]   pass_count_q, pass_count_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;

    // One extra bit so the last-pass compare is exact even at all-ones.
    logic [PASS_WIDTH:0]     pass_inc;
    logic                    last_pass;

    assign pass_inc  = {1'b0, pass_count_q} + 1'b1;
    assign last_pass = (pass_inc == {1'b0, passes_q});

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        passes_d     = passes_q;
        pass_count_d = pass_count_q;
        sync_err_d   = sync_err_q;
        tmo_d        = tmo_q;
        done_d       = 1'b0;

        // Sample path follows the mode currently presented to mem_bank, so
        // strobes are dropped for exactly the cycles mem_bank is in playback.
        data_avail_d = (mode_q == MODE_WRITING) && fe_strobe;
        data_in_d    = (mode_q == MODE_WRITING) ? fe_sample : data_in_q;

        // Frame end handling shared by SYNC (degenerate one-sample frame) and PLAY.
        if ((state_q == ST_PLAY || (state_q == ST_SYNC && mb_frame_start)) && mb_frame_end) begin
            pass_count_d = (&pass_count_q) ? pass_count_q : pass_inc[PASS_WIDTH-1:0];
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    passes_d     = (num_passes == '0) ? PASS_WIDTH'(1) : num_passes;
                    pass_count_d = '0;
                    sync_err_d   = 1'b0;
                    tmo_d        = '0;
                    if (mb_ready) begin
                        state_d = ST_SYNC;
                        mode_d  = MODE_PLAYBACK;
                    end else begin
                        state_d = ST_WAIT_READY;
                    end
                end
            end
            ST_WAIT_READY: begin
                if (mb_ready) begin
                    state_d = ST_SYNC;
                    mode_d  = MODE_PLAYBACK;
                    tmo_d   = '0;
                end
            end
            ST_SYNC: begin
                if (mb_frame_start) begin
                    state_d = ST_PLAY;
                    tmo_d   = '0;
                    if (mb_frame_end && last_pass) begin
                        state_d = ST_IDLE;
                        mode_d  = MODE_WRITING;
                        done_d  = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d    = ST_IDLE;
                    mode_d     = MODE_WRITING;
                    sync_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_PLAY: begin
                if (mb_frame_end && last_pass) begin
                    state_d = ST_IDLE;
                    mode_d  = MODE_WRITING;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_WRITING;
            data_in_q    <= '0;
            data_avail_q <= 1'b0;
            done_q       <= 1'b0;
            sync_err_q   <= 1'b0;
            passes_q     <= '0;
            pass_count_q <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            data_in_q    <= data_in_d;
            data_avail_q <= data_avail_d;
            done_q       <= done_d;
            sync_err_q   <= sync_err_d;
            passes_q     <= passes_d;
            pass_count_q <= pass_count_d;
            tmo_q        <= tmo_d;
        end
    end

    assign mb_mode       = mode_q;
    assign mb_data_in    = data_in_q;
    assign mb_data_avail = data_avail_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign pass_count    = pass_count_q;
    assign sync_err      = sync_err_q;

endmodule

// File: tb/tb_mem_bank_ctrl.sv
module tb_mem_bank_ctrl;

    localparam int SW = 3;
    localparam int PW = 8;

    logic          clk;
    logic          reset_n;
    logic [SW-1:0] fe_sample;
    logic          fe_strobe;
    logic          start;
    logic [PW-1:0] num_passes;
    logic          mb_ready;
    logic          mb_frame_start;
    logic          mb_frame_end;
    logic [SW-1:0] mb_data_in;
    logic          mb_data_avail;
    logic          mb_mode;
    logic          busy;
    logic          done;
    logic [PW-1:0] pass_count;
    logic          sync_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] mon_exp;

    mem_bank_ctrl #(.SAMPLE_WIDTH(SW), .PASS_WIDTH(PW), .SYNC_TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .fe_sample(fe_sample), .fe_strobe(fe_strobe),
        .start(start), .num_passes(num_passes),
        .mb_ready(mb_ready), .mb_frame_start(mb_frame_start), .mb_frame_end(mb_frame_end),
        .mb_data_in(mb_data_in), .mb_data_avail(mb_data_avail), .mb_mode(mb_mode),
        .busy(busy), .done(done), .pass_count(pass_count), .sync_err(sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every sample presented to mem_bank must match the oldest
    // strobe forwarded by the stimulus, and must appear only while writing.
    always @(negedge clk) begin
        if (reset_n && mb_data_avail) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sample_unexpected: got data=%b mode=%b, required no sample", mb_data_in, mb_mode);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mb_data_in !== mon_exp || mb_mode !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sample_data: got data=%b mode=%b, required data=%b mode=0", mb_data_in, mb_mode, mon_exp);
                end else begin
                    $display("sample data=%b ok", mb_data_in);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fe_sample = '0; fe_strobe = 1'b0; start = 1'b0; num_passes = '0;
        mb_ready = 1'b0; mb_frame_start = 1'b0; mb_frame_end = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({mb_mode, mb_data_in, mb_data_avail, busy, done, pass_count, sync_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got mode=%b data=%b avail=%b busy=%b done=%b pc=%0d err=%b, required all 0",
                     mb_mode, mb_data_in, mb_data_avail, busy, done, pass_count, sync_err);
        end
        reset_n = 1'b1;
        tick();
        $display("reset done");
    endtask

    task automatic test_sample_path();
        logic [SW-1:0] s;
        for (int i = 0; i < 20; i++) begin
            if (i % 4 == 0) begin
                s = (i < 8) ? 3'b101 : SW'(i) ^ 3'b110;
                fe_strobe = 1'b1; fe_sample = s;
                exp_q.push_back(s);
            end else begin
                fe_strobe = 1'b0; fe_sample = SW'($urandom);
            end
            tick();
            n_checks++;
            if (mb_data_avail !== (i % 4 == 0)) begin
                n_fail++;
                $display("FAIL sample_avail_%0d: got avail=%b, required %b", i, mb_data_avail, (i % 4 == 0));
            end
        end
        fe_strobe = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sample_drain: got %0d samples missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_wait_ready_play();
        start = 1'b1; num_passes = 8'd2; mb_ready = 1'b0;
        tick();
        start = 1'b0; num_passes = 8'd0;
        n_checks++;
        if (busy !== 1'b1 || mb_mode !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_ready_enter: got busy=%b mode=%b, required busy=1 mode=0", busy, mb_mode);
        end
        repeat (100) tick();
        n_checks++;
        if (busy !== 1'b1 || mb_mode !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_ready_hold: got busy=%b mode=%b, required busy=1 mode=0", busy, mb_mode);
        end
        mb_ready = 1'b1;
        tick();
        mb_ready = 1'b0;
        n_checks++;
        if (mb_mode !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_edge_mode: got mode=%b busy=%b, required mode=1 busy=1", mb_mode, busy);
        end
        // Strobes during playback must be dropped (no scoreboard entries).
        fe_strobe = 1'b1; fe_sample = 3'b011;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (mb_data_avail !== 1'b0) begin
                n_fail++;
                $display("FAIL playback_drop_%0d: got avail=%b, required 0", i, mb_data_avail);
            end
        end
        fe_strobe = 1'b0;
        mb_frame_start = 1'b1;
        tick();
        mb_frame_start = 1'b0;
        // Start while busy must be ignored.
        start = 1'b1; num_passes = 8'd5;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || pass_count !== 8'd0 || sync_err !== 1'b0) begin
            n_fail++;
            $display("FAIL start_ignored: got busy=%b pc=%0d err=%b, required busy=1 pc=0 err=0", busy, pass_count, sync_err);
        end
        mb_frame_end = 1'b1;
        tick();
        mb_frame_end = 1'b0;
        n_checks++;
        if (pass_count !== 8'd1 || done !== 1'b0 || mb_mode !== 1'b1) begin
            n_fail++;
            $display("FAIL first_pass: got pc=%0d done=%b mode=%b, required pc=1 done=0 mode=1", pass_count, done, mb_mode);
        end
        repeat (3) tick();
        mb_frame_end = 1'b1;
        tick();
        mb_frame_end = 1'b0;
        n_checks++;
        if (pass_count !== 8'd2 || done !== 1'b1 || mb_mode !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL last_pass: got pc=%0d done=%b mode=%b busy=%b, required pc=2 done=1 mode=0 busy=0",
                     pass_count, done, mb_mode, busy);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || pass_count !== 8'd2) begin
            n_fail++;
            $display("FAIL done_pulse: got done=%b pc=%0d, required done=0 pc=2", done, pass_count);
        end
        $display("playback request complete");
    endtask

    task automatic test_sync_timeout();
        bit done_seen = 1'b0;
        mb_ready = 1'b1; start = 1'b1; num_passes = 8'd1;
        tick();
        start = 1'b0; mb_ready = 1'b0;
        n_checks++;
        if (mb_mode !== 1'b1 || busy !== 1'b1 || sync_err !== 1'b0 || pass_count !== 8'd0) begin
            n_fail++;
            $display("FAIL sync_enter: got mode=%b busy=%b err=%b pc=%0d, required mode=1 busy=1 err=0 pc=0",
                     mb_mode, busy, sync_err, pass_count);
        end
        for (int i = 1; i < 16; i++) begin
            tick();
            if (done) done_seen = 1'b1;
        end
        n_checks++;
        if (mb_mode !== 1'b1 || sync_err !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_early: got mode=%b err=%b after 15 cycles, required mode=1 err=0", mb_mode, sync_err);
        end
        tick();
        if (done) done_seen = 1'b1;
        n_checks++;
        if (sync_err !== 1'b1 || mb_mode !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_timeout: got err=%b mode=%b busy=%b done=%b, required err=1 mode=0 busy=0 done=0",
                     sync_err, mb_mode, busy, done);
        end
        repeat (3) begin
            tick();
            if (done) done_seen = 1'b1;
        end
        n_checks++;
        if (done_seen || sync_err !== 1'b1) begin
            n_fail++;
            $display("FAIL sync_sticky: got done_seen=%b err=%b, required done_seen=0 err=1", done_seen, sync_err);
        end
        $display("sync timeout handled");
    endtask

    task automatic test_degenerate_frame();
        mb_ready = 1'b1; start = 1'b1; num_passes = 8'd0;
        tick();
        start = 1'b0; mb_ready = 1'b0;
        n_checks++;
        if (sync_err !== 1'b0 || mb_mode !== 1'b1 || pass_count !== 8'd0) begin
            n_fail++;
            $display("FAIL zero_pass_start: got err=%b mode=%b pc=%0d, required err=0 mode=1 pc=0", sync_err, mb_mode, pass_count);
        end
        mb_frame_start = 1'b1; mb_frame_end = 1'b1;
        tick();
        mb_frame_start = 1'b0; mb_frame_end = 1'b0;
        n_checks++;
        if (pass_count !== 8'd1 || done !== 1'b1 || mb_mode !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL one_sample_frame: got pc=%0d done=%b mode=%b busy=%b, required pc=1 done=1 mode=0 busy=0",
                     pass_count, done, mb_mode, busy);
        end
        tick();
        $display("degenerate frame handled");
    endtask

    task automatic test_async_reset();
        mb_ready = 1'b1; start = 1'b1; num_passes = 8'd3;
        tick();
        start = 1'b0; mb_ready = 1'b0; mb_frame_start = 1'b1;
        tick();
        mb_frame_start = 1'b0; mb_frame_end = 1'b1;
        tick();
        mb_frame_end = 1'b0;
        n_checks++;
        if (pass_count !== 8'd1 || busy !== 1'b1 || mb_mode !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_play: got pc=%0d busy=%b mode=%b, required pc=1 busy=1 mode=1", pass_count, busy, mb_mode);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (mb_mode !== 1'b0 || busy !== 1'b0 || pass_count !== 8'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got mode=%b busy=%b pc=%0d done=%b, required all 0", mb_mode, busy, pass_count, done);
        end
        tick();
        reset_n = 1'b1;
        tick();
        $display("async reset handled");
    endtask

    initial begin
        test_reset();
        test_sample_path();
        test_wait_ready_play();
        test_sync_timeout();
        test_degenerate_frame();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
